uart_tx_arbiter: RTL and testbench

- Shares a single UART transmitter among NUM_REQ byte-producing clients using round-robin arbitration.
- Accepts one byte per grant over a per-client valid/ready handshake.
- Issues a one-cycle start pulse to the transmitter, then holds off further grants until the transmitter reports completion.
- Sits between the system-side message sources (status, debug, response formatters) and the uart_tx instance.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, header
// marker and the rotating-priority search helper used by rr_arbiter.
package uart_pkg;

  // Upper bound on requesters the search helper can scan.
  localparam int RR_MAX_REQ = 128;

  // Value placed in the MSB of a header byte to flag it as an id prefix.
  localparam logic HDR_MARK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_HDR_START = 3'd3,
    ST_HDR_WAIT  = 3'd4
  } arb_state_e;

  // First set bit of valid scanning last+1, last+2, ... modulo n; -1 if none.
  function automatic int rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                 input int n, input int last);
    int idx;
    rr_pick = -1;
    for (int i = RR_MAX_REQ; i >= 1; i--) begin
      if (i <= n) begin
        idx = last + i;
        if (idx >= n) idx = idx - n;
        if (valid[idx[6:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection. The winner is combinational from the valid
// vector and the last grant; the pointer only moves when i_update is high.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         i_valid,
  input  logic                       i_update,
  output logic                       o_any,
  output logic [$clog2(NUM_REQ)-1:0] o_winner,
  output logic [NUM_REQ-1:0]         o_onehot
);

  localparam int ID_BW = $clog2(NUM_REQ);

  logic [ID_BW-1:0]      last_grant_q, last_grant_d;
  logic [RR_MAX_REQ-1:0] valid_ext;
  int                    pick;

  // Rotating search starting just after the previous winner.
  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_REQ-1:0] = i_valid;
    pick = rr_pick(valid_ext, NUM_REQ, int'(last_grant_q));
    o_any = (pick >= 0);
    o_winner = o_any ? ID_BW'(pick) : '0;
    o_onehot = o_any ? (NUM_REQ'(1) << o_winner) : '0;
    last_grant_d = (i_update && o_any) ? o_winner : last_grant_q;
  end

  // Pointer register; reset leaves requester 0 with first priority.
  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= ID_BW'(NUM_REQ - 1);
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Optional build macro UART_TX_ARB_ID_PREFIX_EN: each grant first sends a
// header byte {1, zeros, grant id}, then the payload byte.
//
// state        | meaning
// ST_IDLE      | ready offered to the round-robin winner, accept on handshake
// ST_START     | o_tx_start high for this cycle with the payload byte
// ST_WAIT_DONE | holding byte and id until the transmitter reports done
// ST_HDR_START | o_tx_start high for this cycle with the header byte
// ST_HDR_WAIT  | header in flight; done loads the payload and goes to START
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] i_req_data,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic                            o_tx_start,
  output logic [PAYLOAD_BITS-1:0]         o_tx_data,
  input  logic                            i_tx_done,
  output logic                            o_busy,
  output logic [$clog2(NUM_REQ)-1:0]      o_grant_id
);

  localparam int ID_BW = $clog2(NUM_REQ);

  arb_state_e              state_q, state_d;
  logic                    tx_start_q, tx_start_d;
  logic [PAYLOAD_BITS-1:0] tx_data_q, tx_data_d;
  logic [ID_BW-1:0]        grant_id_q, grant_id_d;
  logic                    busy_q, busy_d;
  logic                    accept;
  logic                    arb_any;
  logic [ID_BW-1:0]        arb_winner;
  logic [NUM_REQ-1:0]      arb_onehot;
  logic [PAYLOAD_BITS-1:0] sel_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk      (clk),
    .reset    (reset),
    .i_valid  (i_req_valid),
    .i_update (accept),
    .o_any    (arb_any),
    .o_winner (arb_winner),
    .o_onehot (arb_onehot)
  );

`ifdef UART_TX_ARB_ID_PREFIX_EN
  logic [PAYLOAD_BITS-1:0] payload_q, payload_d;
  logic [PAYLOAD_BITS-1:0] hdr_byte;

  // Header byte: marker in the MSB, grant id in the low bits.
  always_comb begin
    hdr_byte = '0;
    hdr_byte[PAYLOAD_BITS-1] = HDR_MARK;
    hdr_byte[ID_BW-1:0] = arb_winner;
  end

  // Payload held aside while the header byte is on the line.
  always_ff @(posedge clk) begin
    if (reset) payload_q <= '0;
    else       payload_q <= payload_d;
  end
`endif

  // Ready only in IDLE and only to the current winner.
  always_comb begin
    o_req_ready = (state_q == ST_IDLE && !reset) ? arb_onehot : '0;
    sel_data = i_req_data[arb_winner*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    accept     = 1'b0;
`ifdef UART_TX_ARB_ID_PREFIX_EN
    payload_d  = payload_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          accept     = 1'b1;
          grant_id_d = arb_winner;
`ifdef UART_TX_ARB_ID_PREFIX_EN
          payload_d  = sel_data;
          tx_data_d  = hdr_byte;
          state_d    = ST_HDR_START;
`else
          tx_data_d  = sel_data;
          state_d    = ST_START;
`endif
        end
      end
      ST_START:     state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (i_tx_done) state_d = ST_IDLE;
`ifdef UART_TX_ARB_ID_PREFIX_EN
      ST_HDR_START: state_d = ST_HDR_WAIT;
      ST_HDR_WAIT: begin
        if (i_tx_done) begin
          tx_data_d = payload_q;
          state_d   = ST_START;
        end
      end
`endif
      default:      state_d = ST_IDLE;
    endcase
    tx_start_d = (state_d == ST_START) || (state_d == ST_HDR_START);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_grant_id = grant_id_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized transfers
// checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  i_req_valid = '0;
  logic [31:0] i_req_data = '0;
  logic        i_tx_done = 1'b0;
  logic [3:0]  o_req_ready;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic [1:0]  o_grant_id;

  int total = 0;
  int bad = 0;
  int model_last = 3;

  uart_tx_arbiter #(.NUM_REQ(4), .PAYLOAD_BITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .i_tx_done   (i_tx_done),
    .o_busy      (o_busy),
    .o_grant_id  (o_grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Next owner: first valid requester after the previous owner, wrapping.
  function automatic int model_pick(input logic [3:0] m);
    for (int k = 1; k <= 4; k++)
      if (m[(model_last + k) % 4]) return (model_last + k) % 4;
    return -1;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    i_req_valid = '0;
    i_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start_hi", 32'(o_tx_start), 32'd0);
    reset = 1'b0;
    model_last = 3;
    #1;
  endtask

  // Entered at the cycle a start pulse is expected; leaves after the done.
  task automatic byte_phase(input logic [7:0] exp_data, input int id,
                            input bit early, input int delay, input string tag);
    chk({tag, "_start"}, 32'(o_tx_start), 32'd1);
    chk({tag, "_data"},  32'(o_tx_data), 32'(exp_data));
    chk({tag, "_id"},    32'(o_grant_id), 32'(id));
    chk({tag, "_busy"},  32'(o_busy), 32'd1);
    chk({tag, "_rdy0"},  32'(o_req_ready), 32'd0);
    if (early) i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    chk({tag, "_pulse1"}, 32'(o_tx_start), 32'd0);
    chk({tag, "_busy_w"}, 32'(o_busy), 32'd1);
    for (int c = 0; c < delay; c++) begin
      i_req_valid = 4'($urandom_range(0, 15));
      @(negedge clk);
      chk({tag, "_hold"}, {22'd0, o_busy, o_tx_start, o_tx_data},
          {22'd0, 1'b1, 1'b0, exp_data});
      #1;
      chk({tag, "_rdy_w"}, 32'(o_req_ready), 32'd0);
    end
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
  endtask

  // One grant from IDLE; called just after a negedge.
  task automatic xfer(input logic [3:0] mask, input logic [31:0] data,
                      input int delay, input bit early, input string tag);
    int w;
    logic [7:0] pay;
    i_req_valid = mask;
    i_req_data = data;
    #1;
    w = model_pick(mask);
    if (w < 0) begin
      chk({tag, "_none_rdy"}, 32'(o_req_ready), 32'd0);
      @(negedge clk);
      chk({tag, "_none_busy"}, {30'd0, o_busy, o_tx_start}, 32'd0);
      return;
    end
    chk({tag, "_ready"}, 32'(o_req_ready), 32'(4'b0001 << w));
    pay = data[w*8 +: 8];
    model_last = w;
    @(negedge clk);
`ifdef UART_TX_ARB_ID_PREFIX_EN
    byte_phase(8'h80 | 8'(w), w, early, delay, {tag, "_hdr"});
`endif
    byte_phase(pay, w, early, delay, tag);
    chk({tag, "_idle"}, {30'd0, o_busy, o_tx_start}, 32'd0);
  endtask

  initial begin
    @(negedge clk);
    apply_reset();
    chk("rst_outs", {20'd0, o_busy, o_tx_start, o_grant_id, o_tx_data}, 32'd0);
    chk("rst_ready", 32'(o_req_ready), 32'd0);

    xfer(4'b0100, 32'h005A_0000, 10, 1'b0, "single");

    apply_reset();
    for (int i = 0; i < 5; i++) xfer(4'b1111, 32'h1312_1110, 1, 1'b0, "rr");

    xfer(4'b1000, 32'h4400_0000, 0, 1'b0, "wrap_pre");
    xfer(4'b1001, 32'h4400_0011, 0, 1'b0, "wrap0");
    xfer(4'b1000, 32'h4400_0011, 0, 1'b0, "wrap3");

    i_req_valid = '0;
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    chk("idle_done", {30'd0, o_busy, o_tx_start}, 32'd0);
    xfer(4'b0010, 32'h0000_7700, 3, 1'b1, "early_done");

    i_req_valid = 4'b0100;
    i_req_data = 32'h00AB_0000;
    @(negedge clk);
    i_req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_start", 32'(o_tx_start), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    reset = 1'b0;
    model_last = 3;
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    chk("stale_done", {30'd0, o_busy, o_tx_start}, 32'd0);
    @(negedge clk);
    chk("stale_done2", {30'd0, o_busy, o_tx_start}, 32'd0);
    xfer(4'b0011, 32'h0000_2221, 2, 1'b0, "post_rst");

    for (int i = 0; i < 40; i++)
      xfer(4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 4),
           1'($urandom_range(0, 1)), "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
